// File: rtl/reg_access_sequencer_pkg.sv
// Shared types and constants for the register-block access sequencer.
// State encoding, legal register-number width and arbitration mode selectors.
package reg_access_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ADDR  = 3'd1,
      ST_CHECK = 3'd2,
      ST_WRITE = 3'd3,
      ST_READ  = 3'd4,
      ST_CAPT  = 3'd5,
      ST_RESP  = 3'd6
   } state_e;

   localparam int REG_NUM_LEGAL_BITS = 5;

   localparam int ARB_RR    = 0;
   localparam int ARB_FIXED = 1;

   function automatic logic [1:0] onehot2(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/reg_access_sequencer_arbiter.sv
// Two-input arbiter, combinational grant; round-robin or fixed priority to input 0.
// The last-grant pointer only moves when the caller accepts the grant (gnt_take).
module reg_req_arbiter
   import reg_access_sequencer_pkg::*;
#(
   parameter int ARB_MODE = ARB_RR
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] req_vld,
   input  logic       gnt_take,
   output logic       gnt_idx,
   output logic       gnt_vld
);

   logic last_q, last_d;

   always_comb begin
      gnt_vld = |req_vld;
      gnt_idx = 1'b0;
      if (req_vld == 2'b11) begin
         gnt_idx = (ARB_MODE == ARB_FIXED) ? 1'b0 : ~last_q;
      end else begin
         gnt_idx = req_vld[1];
      end
      last_d = last_q;
      if (gnt_take && gnt_vld) begin
         last_d = gnt_idx;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_q <= 1'b0;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/reg_access_sequencer.sv
// Sequences single-word register transactions from two requesters into the register block's
// latch/check/strobe protocol; write 4, read 5, illegal 3 cycles to ack; one transaction at a time.
module reg_access_sequencer
   import reg_access_sequencer_pkg::*;
#(
   parameter int ARB_MODE = ARB_RR,
   parameter int ERRCNT_W = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [1:0]          req_valid,
   input  logic [1:0]          req_write,
   input  logic [63:0]         req_addr,
   input  logic [63:0]         req_wdata,
   output logic [1:0]          req_ack,
   output logic [31:0]         rsp_rdata,
   output logic                rsp_err,
   output logic                busy,
   output logic [ERRCNT_W-1:0] err_count,
   output logic [31:0]         rb_rx_data,
   output logic                rb_reg_num_le,
   output logic                rb_wr_en,
   output logic                rb_rd_en,
   input  logic [31:0]         rb_tx_data,
   input  logic                rb_illegal_reg_num
);

   state_e              state_q, state_d;
   logic                gnt_q, gnt_d;
   logic                write_q, write_d;
   logic [31:0]         addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [ERRCNT_W-1:0] err_count_q, err_count_d;
   logic [1:0]          req_ack_q, req_ack_d;
   logic [31:0]         rsp_rdata_q, rsp_rdata_d;
   logic                rsp_err_q, rsp_err_d;
   logic                busy_q, busy_d;
   logic [31:0]         rb_rx_data_q, rb_rx_data_d;
   logic                rb_reg_num_le_q, rb_reg_num_le_d;
   logic                rb_wr_en_q, rb_wr_en_d;
   logic                rb_rd_en_q, rb_rd_en_d;

   logic gnt_idx, gnt_vld, gnt_take;

   reg_req_arbiter #(.ARB_MODE(ARB_MODE)) u_arb (
      .clk      (clk),
      .reset_n  (reset_n),
      .req_vld  (req_valid),
      .gnt_take (gnt_take),
      .gnt_idx  (gnt_idx),
      .gnt_vld  (gnt_vld)
   );

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      write_d     = write_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      err_count_d = err_count_q;
      rsp_rdata_d = '0;
      rsp_err_d   = 1'b0;
      gnt_take    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (gnt_vld) begin
               gnt_take = 1'b1;
               gnt_d    = gnt_idx;
               write_d  = req_write[gnt_idx];
               addr_d   = gnt_idx ? req_addr[63:32]  : req_addr[31:0];
               wdata_d  = gnt_idx ? req_wdata[63:32] : req_wdata[31:0];
               state_d  = ST_ADDR;
            end
         end
         ST_ADDR:  state_d = ST_CHECK;
         ST_CHECK: begin
            if (rb_illegal_reg_num) begin
               rsp_err_d = 1'b1;
               if (err_count_q != '1) begin
                  err_count_d = err_count_q + 1'b1;
               end
               state_d = ST_RESP;
            end else begin
               state_d = write_q ? ST_WRITE : ST_READ;
            end
         end
         ST_WRITE: state_d = ST_RESP;
         ST_READ:  state_d = ST_CAPT;
         ST_CAPT: begin
            rsp_rdata_d = rb_tx_data;
            state_d     = ST_RESP;
         end
         ST_RESP:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      // Outputs are decoded from the next state so they are registered yet line up with it.
      rb_reg_num_le_d = (state_d == ST_ADDR);
      rb_wr_en_d      = (state_d == ST_WRITE);
      rb_rd_en_d      = (state_d == ST_READ);
      busy_d          = (state_d != ST_IDLE);
      req_ack_d       = (state_d == ST_RESP) ? onehot2(gnt_d) : 2'b00;
      rb_rx_data_d    = '0;
      if (state_d == ST_ADDR) begin
         rb_rx_data_d = addr_d;
      end else if (state_d == ST_WRITE) begin
         rb_rx_data_d = wdata_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= ST_IDLE;
         gnt_q           <= 1'b0;
         write_q         <= 1'b0;
         addr_q          <= '0;
         wdata_q         <= '0;
         err_count_q     <= '0;
         req_ack_q       <= '0;
         rsp_rdata_q     <= '0;
         rsp_err_q       <= 1'b0;
         busy_q          <= 1'b0;
         rb_rx_data_q    <= '0;
         rb_reg_num_le_q <= 1'b0;
         rb_wr_en_q      <= 1'b0;
         rb_rd_en_q      <= 1'b0;
      end else begin
         state_q         <= state_d;
         gnt_q           <= gnt_d;
         write_q         <= write_d;
         addr_q          <= addr_d;
         wdata_q         <= wdata_d;
         err_count_q     <= err_count_d;
         req_ack_q       <= req_ack_d;
         rsp_rdata_q     <= rsp_rdata_d;
         rsp_err_q       <= rsp_err_d;
         busy_q          <= busy_d;
         rb_rx_data_q    <= rb_rx_data_d;
         rb_reg_num_le_q <= rb_reg_num_le_d;
         rb_wr_en_q      <= rb_wr_en_d;
         rb_rd_en_q      <= rb_rd_en_d;
      end
   end

   assign req_ack       = req_ack_q;
   assign rsp_rdata     = rsp_rdata_q;
   assign rsp_err       = rsp_err_q;
   assign busy          = busy_q;
   assign err_count     = err_count_q;
   assign rb_rx_data    = rb_rx_data_q;
   assign rb_reg_num_le = rb_reg_num_le_q;
   assign rb_wr_en      = rb_wr_en_q;
   assign rb_rd_en      = rb_rd_en_q;

endmodule

// File: tb/tb_reg_access_sequencer.sv
// Two sequencers (round-robin/16-bit counter and fixed-priority/4-bit counter), each with a
// register-block model, checked against a transaction-level reference model.
module tb_reg_access_sequencer;
   import reg_access_sequencer_pkg::*;

   logic clk = 1'b0;
   always #4 clk = ~clk;

   logic        reset_n;
   logic [1:0]  req_valid [2];
   logic [1:0]  req_write [2];
   logic [63:0] req_addr  [2];
   logic [63:0] req_wdata [2];
   logic [1:0]  req_ack   [2];
   logic [31:0] rsp_rdata [2];
   logic        rsp_err   [2];
   logic        busy      [2];
   logic [15:0] ec0;
   logic [3:0]  ec1;
   logic [31:0] rb_rx [2];
   logic [31:0] rb_tx [2];
   logic        rb_le [2];
   logic        rb_wr [2];
   logic        rb_rd [2];
   logic        rb_ill [2];

   reg_access_sequencer #(.ARB_MODE(ARB_RR), .ERRCNT_W(16)) dut_rr (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid[0]), .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
      .req_ack(req_ack[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .busy(busy[0]), .err_count(ec0),
      .rb_rx_data(rb_rx[0]), .rb_reg_num_le(rb_le[0]), .rb_wr_en(rb_wr[0]), .rb_rd_en(rb_rd[0]),
      .rb_tx_data(rb_tx[0]), .rb_illegal_reg_num(rb_ill[0])
   );

   reg_access_sequencer #(.ARB_MODE(ARB_FIXED), .ERRCNT_W(4)) dut_fp (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid[1]), .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
      .req_ack(req_ack[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .busy(busy[1]), .err_count(ec1),
      .rb_rx_data(rb_rx[1]), .rb_reg_num_le(rb_le[1]), .rb_wr_en(rb_wr[1]), .rb_rd_en(rb_rd[1]),
      .rb_tx_data(rb_tx[1]), .rb_illegal_reg_num(rb_ill[1])
   );

   // Register-block environment: latches the number on le, writes on wr_en, registered readback.
   logic [31:0] env_lat  [2];
   logic [31:0] env_regs [2][32];
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (rb_le[d]) env_lat[d] <= rb_rx[d];
         if (rb_wr[d]) env_regs[d][env_lat[d][4:0]] <= rb_rx[d];
         if (rb_rd[d]) rb_tx[d] <= env_regs[d][env_lat[d][4:0]];
      end
   end
   assign rb_ill[0] = (env_lat[0] >> REG_NUM_LEGAL_BITS) != 0;
   assign rb_ill[1] = (env_lat[1] >> REG_NUM_LEGAL_BITS) != 0;

   // Bus monitor: strobe counts, data seen on strobes, protocol violations.
   int          cyc;
   int          le_cnt [2], wr_cnt [2], rd_cnt [2], viol [2], le_at [2], wr_at [2];
   logic [31:0] le_dat [2], wr_dat [2];
   always @(posedge clk) begin
      #1;
      cyc++;
      for (int d = 0; d < 2; d++) begin
         if (rb_le[d]) begin le_cnt[d]++; le_dat[d] = rb_rx[d]; le_at[d] = cyc; end
         if (rb_wr[d]) begin wr_cnt[d]++; wr_dat[d] = rb_rx[d]; wr_at[d] = cyc; end
         if (rb_rd[d]) rd_cnt[d]++;
         if (int'(rb_le[d]) + int'(rb_wr[d]) + int'(rb_rd[d]) > 1) viol[d]++;
         if (!rb_le[d] && !rb_wr[d] && rb_rx[d] != 32'h0) viol[d]++;
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference model state
   logic        last_g [2];
   int unsigned ecnt_m [2];
   int unsigned ecnt_max [2];
   logic [31:0] mregs [2][32];

   function automatic logic [15:0] ecnt(input int d);
      return (d == 1) ? {12'h0, ec1} : ec0;
   endfunction

   function automatic logic [31:0] rand_addr();
      if ($urandom_range(0, 3) == 0) return $urandom | (32'h1 << $urandom_range(5, 31));
      return 32'($urandom_range(0, 31));
   endfunction

   task automatic run_txn(input int d, input logic [1:0] vm, input logic [1:0] w,
                          input logic [63:0] a, input logic [63:0] wd);
      int          n;
      logic        g;
      logic        gw, ill;
      logic [31:0] ga, gwd, exp_rd;
      int          exp_lat;
      if (vm == 2'b11) g = (d == 1) ? 1'b0 : ~last_g[d];
      else             g = vm[1];
      last_g[d] = g;
      ga  = g ? a[63:32]  : a[31:0];
      gwd = g ? wd[63:32] : wd[31:0];
      gw  = w[g];
      ill = ga > 32'd31;
      exp_lat = ill ? 3 : (gw ? 4 : 5);
      exp_rd  = (!ill && !gw) ? mregs[d][ga[4:0]] : 32'h0;
      if (ill && ecnt_m[d] < ecnt_max[d]) ecnt_m[d]++;

      le_cnt[d] = 0; wr_cnt[d] = 0; rd_cnt[d] = 0; viol[d] = 0;
      req_write[d] = w; req_addr[d] = a; req_wdata[d] = wd; req_valid[d] = vm;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         // Requests change mid-transaction; the DUT must keep what it latched at grant.
         if (n == 2) begin
            req_addr[d]  = {rand_addr(), rand_addr()};
            req_wdata[d] = {$urandom, $urandom};
            req_write[d] = 2'($urandom);
         end
      end while (req_ack[d] == 2'b00 && n < 20);

      chk("ack", req_ack[d], g ? 2'b10 : 2'b01);
      chk("latency", n, exp_lat);
      chk("rsp_err", rsp_err[d], ill);
      chk("rsp_rdata", rsp_rdata[d], exp_rd);
      chk("busy_resp", busy[d], 1'b1);
      chk("err_count", ecnt(d), ecnt_m[d]);
      chk("le_cnt", le_cnt[d], 1);
      chk("le_dat", le_dat[d], ga);
      chk("wr_cnt", wr_cnt[d], (!ill && gw) ? 1 : 0);
      chk("rd_cnt", rd_cnt[d], (!ill && !gw) ? 1 : 0);
      chk("bus_viol", viol[d], 0);
      if (!ill && gw) begin
         chk("wr_dat", wr_dat[d], gwd);
         chk("wr_after_le", wr_at[d] - le_at[d], 2);
         mregs[d][ga[4:0]] = gwd;
      end
      req_valid[d] = 2'b00;
      @(negedge clk);
      chk("busy_idle", busy[d], 1'b0);
      chk("ack_pulse", req_ack[d], 2'b00);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0;
      ecnt_max[0] = 32'hFFFF;
      ecnt_max[1] = 32'hF;
      for (int d = 0; d < 2; d++) begin
         req_valid[d] = '0; req_write[d] = '0; req_addr[d] = '0; req_wdata[d] = '0;
         last_g[d] = 1'b0; ecnt_m[d] = 0; rb_tx[d] = '0; env_lat[d] = '0;
         for (int i = 0; i < 32; i++) begin
            env_regs[d][i] = (i * 32'h01010101) ^ 32'hA5A5_0000;
            mregs[d][i]    = (i * 32'h01010101) ^ 32'hA5A5_0000;
         end
      end
      env_regs[0][5] = 32'hDEADBEEF;
      mregs[0][5]    = 32'hDEADBEEF;

      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("rst_ack", req_ack[d], 2'b00);
         chk("rst_busy", busy[d], 1'b0);
         chk("rst_strobes", {rb_le[d], rb_wr[d], rb_rd[d]}, 3'b000);
         chk("rst_rx", rb_rx[d], 32'h0);
         chk("rst_rsp", {rsp_err[d], rsp_rdata[d]}, 33'h0);
         chk("rst_errcnt", ecnt(d), 16'h0);
      end
      reset_n = 1'b1;
      @(negedge clk);

      run_txn(0, 2'b01, 2'b01, {32'h0, 32'h2}, {32'h0, 32'd70000});
      run_txn(0, 2'b10, 2'b00, {32'h5, 32'h0}, 64'h0);
      run_txn(0, 2'b01, 2'b01, {32'h0, 32'h20}, 64'h0);

      for (int i = 0; i < 4; i++)
         run_txn(0, 2'b11, 2'($urandom), {rand_addr(), rand_addr()}, {$urandom, $urandom});
      for (int i = 0; i < 4; i++)
         run_txn(1, 2'b11, 2'($urandom), {rand_addr(), rand_addr()}, {$urandom, $urandom});

      // Drive the 4-bit error counter past saturation.
      for (int i = 0; i < 18; i++)
         run_txn(1, 2'b01, 2'($urandom), {$urandom, 32'h40 | $urandom}, {$urandom, $urandom});

      for (int i = 0; i < 150; i++)
         run_txn($urandom_range(0, 1), 2'($urandom_range(1, 3)), 2'($urandom),
                 {rand_addr(), rand_addr()}, {$urandom, $urandom});

      // Asynchronous reset in the middle of a read.
      req_write[0] = 2'b00; req_addr[0] = 64'h3; req_valid[0] = 2'b01;
      repeat (3) @(negedge clk);
      chk("rd_before_rst", rb_rd[0], 1'b1);
      reset_n = 1'b0;
      #1;
      chk("rst_mid_rd", rb_rd[0], 1'b0);
      chk("rst_mid_busy", busy[0], 1'b0);
      chk("rst_mid_ack", req_ack[0], 2'b00);
      chk("rst_mid_errcnt", ecnt(1), 16'h0);
      @(negedge clk);
      req_valid[0] = 2'b00;
      repeat (2) @(negedge clk);
      chk("rst_hold_ack", req_ack[0], 2'b00);
      reset_n = 1'b1;
      for (int d = 0; d < 2; d++) begin
         last_g[d] = 1'b0;
         ecnt_m[d] = 0;
      end
      @(negedge clk);
      run_txn(0, 2'b01, 2'b00, {32'h0, 32'h3}, 64'h0);
      run_txn(0, 2'b11, 2'b11, {32'h9, 32'h8}, {$urandom, $urandom});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/reg_access_sequencer.md
Name: reg_access_sequencer

Overview:
Sole driver of the register block's Master-FPGA access port (register-number latch, write and read strobes, and the rx/tx data buses). It arbitrates single-word register transactions from two requesters: requester 0 is the Master FPGA link decoder, and requester 1 is the local start-up/config engine. It sequences each transaction into the register block's address-latch / check / strobe protocol and returns read data or an error.

Parameters:
ARB_MODE, 0, 0 = round-robin between requesters, 1 = fixed priority to requester 0
ERRCNT_W, 16, width of saturating illegal-access counter

Ports:
clk  in  1  125 MHz interconnect clock
reset_n  in  1  asynchronous, active-low reset
req_valid  in  2  per-requester request; level, held until matching ack bit
req_write  in  2  per-requester: 1 = write, 0 = read
req_addr  in  2x32  per-requester register number (packed, [31:0] = req0)
req_wdata  in  2x32  per-requester write data
req_ack  out  2  one-cycle completion pulse to the granted requester
rsp_rdata  out  32  read data, valid with req_ack (0 for writes/errors)
rsp_err  out  1  illegal register number, valid with req_ack
busy  out  1  high whenever FSM is not IDLE
err_count  out  ERRCNT_W  saturating count of illegal accesses
rb_rx_data  out  32  data/address bus to register block
rb_reg_num_le  out  1  register-number latch enable
rb_wr_en  out  1  register write strobe
rb_rd_en  out  1  register read strobe
rb_tx_data  in  32  register block readback (registered; valid 1 cycle after rd_en)
rb_illegal_reg_num  in  1  high when latched register number has bits [31:5] non-zero

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous, active-low. While reset_n is low, all outputs are 0, the FSM is in IDLE, the grant pointer is 0 and err_count is 0.
- Reset mid-transaction: the transaction is abandoned with no ack. The requester must hold or re-issue.
- All outputs are registered.
- FSM states: IDLE, ADDR, CHECK, WRITE, READ, CAPT, RESP.
- IDLE: if any req_valid, grant one requester, latch its write/addr/wdata internally, go to ADDR.
- Arbitration, ARB_MODE=0: if both requesters are valid, grant the one not granted last. If only one is valid, grant it. The last-grant pointer updates on grant.
- Arbitration, ARB_MODE=1: requester 0 always wins ties.
- ADDR: rb_rx_data = addr, rb_reg_num_le = 1 (one cycle), then go to CHECK.
- CHECK: rb_illegal_reg_num now reflects the new address.
  - If illegal: set the error flag and go to RESP. No wr_en or rd_en is issued.
  - Else go to WRITE if write, otherwise READ.
- WRITE: rb_rx_data = wdata, rb_wr_en = 1 (one cycle), then go to RESP.
- READ: rb_rd_en = 1 (one cycle), then go to CAPT.
- CAPT: sample rb_tx_data into the rdata holding register, then go to RESP.
- RESP: req_ack[grant] = 1 for one cycle, with rsp_rdata and rsp_err valid. Return to IDLE.
- Requesters must deassert req_valid in the cycle after ack. A valid still high in IDLE is treated as a new request.
- rb_rx_data is 0 in every state except ADDR and WRITE. The three strobes are never asserted together.
- Latency from request sampled in IDLE to ack:
  - write: 4 cycles
  - read: 5 cycles
  - illegal access: 3 cycles
- Throughput: one transaction per (latency+1) cycles. No pipelining.
- err_count increments once per illegal access and saturates at all-ones.
- req_* inputs are ignored outside IDLE. Changing them mid-transaction has no effect, because they are latched at grant.
- busy = (state != IDLE).

Decomposition:
- Shared package holds:
  - FSM state encoding constants
  - REG_NUM_LEGAL_BITS = 5
  - ARB_RR = 0 and ARB_FIXED = 1
- Sub-module reg_req_arbiter: 2-input round-robin/fixed-priority arbiter with a last-grant pointer. It outputs the grant index and a grant-valid signal.
- The FSM and datapath stay in the top module.

Test Plan:
1. Write, req0: write addr 0x2, data 70000 → rb_reg_num_le with rb_rx_data=0x00000002, 2 cycles later rb_wr_en with rb_rx_data=0x00011170, req_ack[0] 4 cycles after request, rsp_err=0, rd_en never high.
2. Read, req1: read addr 0x5 with register-block model returning 0xDEADBEEF → rb_rd_en once, req_ack[1] at cycle 5, rsp_rdata=0xDEADBEEF.
3. Illegal access: write addr 0x00000020 → no rb_wr_en, ack at cycle 3, rsp_err=1, err_count=1. Repeat 2^16+1 times with ERRCNT_W=16 → err_count holds 0xFFFF.
4. Simultaneous requests, ARB_MODE=0: both valid continuously → acks alternate 0,1,0,1. With ARB_MODE=1 → requester 1 starves while requester 0 keeps requesting.
5. Reset mid-transaction: assert reset_n=0 asynchronously during READ → strobes and ack drop immediately, busy=0, no ack issued. After release, a re-issued request completes normally.
6. Input stability: change req_addr[0] from 0x3 to 0x7 during CHECK → rb_rx_data in ADDR was 0x3 and the transaction completes for 0x3.
